// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a busy scoreboard.
//  - NUM_RD combinational read ports with zero latency.
//  - Two clocked write ports: A (writeback) and B (load/aux). When both
//    target the same register in one cycle, port A wins.
//  - One busy bit per register. sb_set marks a register busy and a write
//    to it clears the bit. A set wins over a clear in the same cycle,
//    because a new producer can issue behind the one that is retiring.
//  - ZERO_REG=1 hard-wires register 0: it reads 0, it is never busy, and
//    writes and sb_set to it are dropped.
//  - Addresses >= NUM_REGS read 0 with busy 0. Writes to them are dropped.
//  - Optional macro WRITE_BYPASS_EN forwards same-cycle write data onto any
//    matching read port, using the same port-A-first priority. Without the
//    macro, reads see stored state only.
module regfile_mp #(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 32,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr
);

  localparam bit          HAS_ZERO  = (ZERO_REG != 0);
  // One bit wider than an address, so that NUM_REGS == 2**AW still fits.
  localparam logic [AW:0] REG_LIMIT = NUM_REGS[AW:0];

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [AW-1:0]     addr_t;

  word_t               regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;

  // Per-register strobes decoded from the write and scoreboard ports.
  logic [NUM_REGS-1:0] wa_hit;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] sb_hit;

  // True when the address maps onto real storage that is not the hard-wired
  // zero register.
  function automatic logic is_live(input addr_t a);
    return ({1'b0, a} < REG_LIMIT) && !(HAS_ZERO && (a == '0));
  endfunction

  // Decode the write and set strobes per register. Out-of-range addresses
  // and the hard-wired zero match nothing, so they are dropped.
  always_comb begin
    // NOTE: every output gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
    wa_hit = '0;
    wb_hit = '0;
    sb_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (is_live(addr_t'(r))) begin
        wa_hit[r] = wa_en  && (wa_addr == addr_t'(r));
        wb_hit[r] = wb_en  && (wb_addr == addr_t'(r));
        sb_hit[r] = sb_set && (sb_addr == addr_t'(r));
      end
    end
  end

  // Register storage. Port A is checked first, so it wins over port B.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array has an explicit reset because reads must return 0 after reset. That keeps it in flops rather than a RAM macro.
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        // NOTE: non-blocking (<=) so every register samples pre-edge values regardless of statement order.
        if (wa_hit[r]) begin
          regs_q[r] <= wa_data;
        end else if (wb_hit[r]) begin
          regs_q[r] <= wb_data;
        end
      end
    end
  end

  // Busy scoreboard: set beats clear, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= sb_hit | (busy_q & ~(wa_hit | wb_hit));
    end
  end

  // Read ports. Each port gets its own mux over storage, plus an optional
  // bypass from the same-cycle write ports.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    addr_t addr;
    logic  live;
    word_t data;
    logic  busy;

    assign addr = rd_addr[p*AW +: AW];
    assign live = is_live(addr);

`ifdef WRITE_BYPASS_EN
    // Stored value, overridden by a matching same-cycle write (port A first).
    // The bypass is gated by rst_n so that reads stay zero while reset is held.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (live) begin
        data = regs_q[addr];
        busy = busy_q[addr];
        if (rst_n && wa_en && (wa_addr == addr)) begin
          data = wa_data;
          busy = sb_set && (sb_addr == addr);
        end else if (rst_n && wb_en && (wb_addr == addr)) begin
          data = wb_data;
          busy = sb_set && (sb_addr == addr);
        end
      end
    end
`else
    // Stored value only. A write becomes visible the cycle after its edge.
    always_comb begin
      data = '0;
      busy = 1'b0;
      if (live) begin
        data = regs_q[addr];
        busy = busy_q[addr];
      end
    end
`endif

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign rd_busy[p]                  = busy;
  end

endmodule
